wb_port_arbiter: RTL and testbench

- Writeback-side arbiter placed directly upstream of the register file's single write port.
- Merges two result sources into the registered ctrl_writeEnable / ctrl_writeReg / data_writeReg triple that drives the register file:
  - the in-order pipeline writeback, which is never stalled;
  - the multicycle mult/div unit's completions, which use a valid/ready handshake.
- Mult/div results that lose arbitration wait in a small FIFO.
- A per-register pending mask is exported to hazard logic.

---
 rtl/wb_port_arbiter_if.sv | 23 ++
 rtl/wb_port_arbiter.sv | 91 +++++++++
 tb/tb_wb_port_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: pipeline/mult-div result inputs and register-file write port bundle.
interface wb_port_arbiter_if;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [31:0] pending_mask;
    logic [15:0] stall_count;
    modport slave (
        input  pipe_we, pipe_rd, pipe_data, md_valid, md_rd, md_data,
        output md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, pending_mask, stall_count
    );
    modport master (
        output pipe_we, pipe_rd, pipe_data, md_valid, md_rd, md_data,
        input  md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, pending_mask, stall_count
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: merges pipeline writeback and buffered mult/div results onto one register-file write port.
// Optional macro WB_STALL_COUNT_EN enables the saturating md backpressure counter on stall_count.
module wb_port_arbiter #(
    parameter int DEPTH = 4
) (
    input logic clock,
    input logic ctrl_reset,
    wb_port_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    head, tail;
    logic [AW:0]      count, count_n;
    logic [DEPTH-1:0] valid_q, valid_n;
    logic [4:0]       rd_q [DEPTH];
    logic [4:0]       rd_n [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_n [DEPTH];
    logic             pipe_req, md_acc, pop, bypass, push, we_n;
    logic [4:0]       wreg_n;
    logic [31:0]      wdata_n, pm_n;

    assign bus.md_ready = count != (AW+1)'(DEPTH);
    assign pipe_req = bus.pipe_we && bus.pipe_rd != 5'd0;
    assign md_acc   = bus.md_valid && bus.md_ready && bus.md_rd != 5'd0;
    assign pop      = !pipe_req && count != '0;
    assign bypass   = !pipe_req && count == '0 && md_acc;
    // An md result racing a same-register pipeline write is older, so it is dropped.
    assign push     = md_acc && !bypass && !(pipe_req && bus.md_rd == bus.pipe_rd);
    assign we_n     = pipe_req || (pop ? valid_q[head] : bypass);
    assign wreg_n   = pipe_req ? bus.pipe_rd : pop ? rd_q[head] : bus.md_rd;
    assign wdata_n  = pipe_req ? bus.pipe_data : pop ? data_q[head] : bus.md_data;
    assign count_n  = count + (AW+1)'(push) - (AW+1)'(pop);

    always_comb begin
        valid_n = '0;
        pm_n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_n[i] = valid_q[i] && !(pipe_req && rd_q[i] == bus.pipe_rd) && !(pop && head == AW'(i));
            rd_n[i] = rd_q[i];
            data_n[i] = data_q[i];
            if (push && tail == AW'(i)) begin
                valid_n[i] = 1'b1;
                rd_n[i] = bus.md_rd;
                data_n[i] = bus.md_data;
            end
            if (valid_n[i]) pm_n[rd_n[i]] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i] <= '0;
                data_q[i] <= '0;
            end
            bus.ctrl_writeEnable <= 1'b0;
            bus.ctrl_writeReg <= '0;
            bus.data_writeReg <= '0;
            bus.pending_mask <= '0;
        end else begin
            head <= head + AW'(pop);
            tail <= tail + AW'(push);
            count <= count_n;
            valid_q <= valid_n;
            rd_q <= rd_n;
            data_q <= data_n;
            bus.ctrl_writeEnable <= we_n;
            if (we_n) begin
                bus.ctrl_writeReg <= wreg_n;
                bus.data_writeReg <= wdata_n;
            end
            bus.pending_mask <= pm_n;
        end
    end

`ifdef WB_STALL_COUNT_EN
    logic [15:0] stall_q;
    always_ff @(posedge clock) begin
        if (!ctrl_reset) stall_q <= '0;
        else if (bus.md_valid && !bus.md_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
    assign bus.stall_count = stall_q;
`else
    assign bus.stall_count = 16'd0;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: scoreboard bench; expected register-file writes are queued, a monitor pops on each write.
module tb_wb_port_arbiter;
    logic clock = 1'b0;
    logic ctrl_reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [36:0] expq [$];

`ifdef WB_STALL_COUNT_EN
    localparam logic [15:0] STALL_EXP = 16'd2;
`else
    localparam logic [15:0] STALL_EXP = 16'd0;
`endif

    wb_port_arbiter_if bus();

    wb_port_arbiter #(.DEPTH(4)) dut (
        .clock(clock),
        .ctrl_reset(ctrl_reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (bus.ctrl_writeEnable === 1'b1) begin
            if (expq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got r%0d=0x%0h expected no write", bus.ctrl_writeReg, bus.data_writeReg);
            end else begin
                chk("write", {bus.ctrl_writeReg, bus.data_writeReg}, expq.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
        expq.push_back({rd, d});
    endtask

    task automatic cyc(input logic pwe, input logic [4:0] prd, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        bus.pipe_we = pwe;
        bus.pipe_rd = prd;
        bus.pipe_data = pd;
        bus.md_valid = mv;
        bus.md_rd = mrd;
        bus.md_data = md;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.pipe_we = 0; bus.pipe_rd = 0; bus.pipe_data = 0;
        bus.md_valid = 0; bus.md_rd = 0; bus.md_data = 0;

        for (int i = 0; i < 2; i++) begin
            cyc(1, 5, 32'h55, 0, 0, 0);
            chk("rst_we", 37'(bus.ctrl_writeEnable), 37'd0);
            chk("rst_pm", 37'(bus.pending_mask), 37'd0);
            chk("rst_ready", 37'(bus.md_ready), 37'd1);
        end
        chk("rst_stall", 37'(bus.stall_count), 37'd0);
        ctrl_reset = 1'b1;
        expect_wr(5, 32'h55);
        cyc(1, 5, 32'h55, 0, 0, 0);
        chk("first_we", 37'(bus.ctrl_writeEnable), 37'd1);
        idle(1);

        expect_wr(3, 32'h11);
        expect_wr(7, 32'h22);
        cyc(1, 3, 32'h11, 1, 7, 32'h22);
        chk("prio_pm1", 37'(bus.pending_mask), 37'h80);
        idle(1);
        chk("prio_pm2", 37'(bus.pending_mask), 37'h0);
        idle(1);

        for (int k = 0; k < 6; k++) begin
            int m;
            m = (k > 4) ? 4 : k;
            chk("full_ready", 37'(bus.md_ready), (k < 4) ? 37'd1 : 37'd0);
            expect_wr(1, 32'h100 + k);
            cyc(1, 1, 32'h100 + k, 1, 5'(8 + m), 32'h800 + m);
            if (k == 0) chk("full_pm0", 37'(bus.pending_mask), 37'h100);
        end
        chk("full_pm", 37'(bus.pending_mask), 37'hF00);
        chk("stall_cnt", 37'(bus.stall_count), 37'(STALL_EXP));
        for (int k = 0; k < 4; k++) expect_wr(5'(8 + k), 32'h800 + k);
        idle(4);
        chk("drain_pm", 37'(bus.pending_mask), 37'h0);
        chk("drain_ready", 37'(bus.md_ready), 37'd1);
        idle(1);

        expect_wr(2, 32'h20);
        cyc(1, 2, 32'h20, 1, 9, 32'hAA);
        chk("waw_pm1", 37'(bus.pending_mask), 37'h200);
        expect_wr(9, 32'hBB);
        cyc(1, 9, 32'hBB, 0, 0, 0);
        chk("waw_pm2", 37'(bus.pending_mask), 37'h0);
        idle(1);
        chk("waw_bubble", 37'(bus.ctrl_writeEnable), 37'd0);
        chk("waw_ready", 37'(bus.md_ready), 37'd1);
        idle(1);

        cyc(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
        chk("r0_we", 37'(bus.ctrl_writeEnable), 37'd0);
        chk("r0_pm", 37'(bus.pending_mask), 37'h0);
        expect_wr(4, 32'h44);
        cyc(1, 0, 32'hDEAD, 1, 4, 32'h44);
        chk("byp_reg", 37'(bus.ctrl_writeReg), 37'd4);
        chk("byp_pm", 37'(bus.pending_mask), 37'h0);
        expect_wr(6, 32'h66);
        cyc(1, 6, 32'h66, 1, 6, 32'h67);
        chk("same_rd_pm", 37'(bus.pending_mask), 37'h0);
        idle(2);

        for (int k = 0; k < 3; k++) begin
            expect_wr(1, 32'h300 + k);
            cyc(1, 1, 32'h300 + k, 1, 5'(13 + k), 32'hD00 + k);
        end
        chk("mid_pm", 37'(bus.pending_mask), 37'hE000);
        ctrl_reset = 1'b0;
        idle(1);
        chk("mid_rst_we", 37'(bus.ctrl_writeEnable), 37'd0);
        chk("mid_rst_pm", 37'(bus.pending_mask), 37'h0);
        chk("mid_rst_ready", 37'(bus.md_ready), 37'd1);
        ctrl_reset = 1'b1;
        idle(4);
        chk("post_rst_pm", 37'(bus.pending_mask), 37'h0);
        chk("queue_empty", 37'(expq.size()), 37'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
